quad_paddle_ctrl: RTL and testbench

//   Turns one rotary quadrature encoder (two raw pin inputs) into a paddle Y position for the

---
 rtl/quad_paddle_ctrl_if.sv | 22 ++
 rtl/quad_paddle_ctrl.sv | 130 +++++++++++++
 tb/tb_quad_paddle_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/quad_paddle_ctrl_if.sv
// rtl/quad_paddle_ctrl_if.sv - encoder pins, frame strobe and paddle outputs
interface quad_paddle_ctrl_if #(
    parameter int WIDTH = 10
);
    logic             a;
    logic             b;
    logic             vsync;
    logic [WIDTH-1:0] move;
    logic             step_up;
    logic             step_dn;
    logic             err;

    modport master (
        output a, b, vsync,
        input  move, step_up, step_dn, err
    );

    modport slave (
        input  a, b, vsync,
        output move, step_up, step_dn, err
    );
endinterface

// File: rtl/quad_paddle_ctrl.sv
// rtl/quad_paddle_ctrl.sv - quadrature encoder to frame-latched paddle position
module quad_paddle_ctrl #(
    parameter int WIDTH      = 10,
    parameter int DEB_CYCLES = 1024,
    parameter int STEP       = 4,
    parameter int PMIN       = 0,
    parameter int PMAX       = 416,
    parameter int PRESET     = 208
) (
    input  logic                clk,
    input  logic                rst_n,
    quad_paddle_ctrl_if.slave   pif
);
    localparam int DW       = $clog2(DEB_CYCLES) + 1;
    localparam int ARM_LAST = DEB_CYCLES + 2;
    localparam int AW       = $clog2(ARM_LAST + 1) + 1;

    localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [AW-1:0]    ARM_END  = AW'(ARM_LAST);
    localparam logic [WIDTH:0]   STEP_X   = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]   PMAX_X   = (WIDTH + 1)'(PMAX);
    localparam logic [WIDTH:0]   LOW_X    = (WIDTH + 1)'(PMIN + STEP);
    localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] PMIN_V   = WIDTH'(PMIN);
    localparam logic [WIDTH-1:0] PMAX_V   = WIDTH'(PMAX);
    localparam logic [WIDTH-1:0] PRESET_V = WIDTH'(PRESET);

    typedef enum logic {ARM = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       filt;
    logic [1:0]       prev;
    logic [DW-1:0]    deb_cnt;
    logic [AW-1:0]    arm_cnt;
    logic [WIDTH-1:0] pos_acc;
    logic [WIDTH-1:0] move;
    logic [WIDTH:0]   pos_x;
    logic [WIDTH:0]   sum_x;
    logic             vsync_q;
    logic             step_up;
    logic             step_dn;
    logic             err;
    logic             dec_inc;
    logic             dec_dec;
    logic             dec_bad;

    // Two-flop synchroniser followed by a level filter; filt only moves after
    // DEB_CYCLES consecutive cycles of the same differing level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 2'b00;
            sync2   <= 2'b00;
            filt    <= 2'b00;
            deb_cnt <= '0;
        end else begin
            sync1 <= {pif.a, pif.b};
            sync2 <= sync1;
            if (sync2 == filt) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                filt    <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ARM;
        else        state <= state_nx;
    end

    // ARM waits long enough for the power-on pin level to settle into filt.
    always_comb begin
        state_nx = state;
        if (state == ARM && arm_cnt == ARM_END) state_nx = RUN;
    end

    always_comb begin
        dec_inc = 1'b0;
        dec_dec = 1'b0;
        dec_bad = 1'b0;
        if (state == RUN && filt != prev) begin
            case ({prev, filt})
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: dec_inc = 1'b1;
                4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: dec_dec = 1'b1;
                default:                                dec_bad = 1'b1;
            endcase
        end
    end

    assign pos_x = {1'b0, pos_acc};
    assign sum_x = pos_x + STEP_X;

    // prev tracks filt every cycle, so outside a change it already equals filt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arm_cnt <= '0;
            prev    <= 2'b00;
            pos_acc <= PRESET_V;
            move    <= PRESET_V;
            vsync_q <= 1'b0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            err     <= 1'b0;
        end else begin
            prev    <= filt;
            vsync_q <= pif.vsync;
            step_up <= dec_dec;
            step_dn <= dec_inc;
            if (state == ARM) arm_cnt <= arm_cnt + AW'(1);
            if (dec_bad) err <= 1'b1;
            if (pif.vsync && !vsync_q) move <= pos_acc;
            if (dec_inc) begin
                pos_acc <= (sum_x > PMAX_X) ? PMAX_V : sum_x[WIDTH-1:0];
            end else if (dec_dec) begin
                pos_acc <= (pos_x < LOW_X) ? PMIN_V : pos_acc - STEP_V;
            end
        end
    end

    assign pif.move    = move;
    assign pif.step_up = step_up;
    assign pif.step_dn = step_dn;
    assign pif.err     = err;
endmodule

// File: tb/tb_quad_paddle_ctrl.sv
// tb/tb_quad_paddle_ctrl.sv - scoreboard bench for quad_paddle_ctrl
`timescale 1ns/1ps
module tb_quad_paddle_ctrl;
    localparam int WIDTH  = 10;
    localparam int DEB    = 4;
    localparam int STEP   = 4;
    localparam int PMIN   = 0;
    localparam int PMAX   = 416;
    localparam int PRESET = 208;
    localparam int LAT    = DEB + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    quad_paddle_ctrl_if #(.WIDTH(WIDTH)) pif ();

    quad_paddle_ctrl #(
        .WIDTH(WIDTH), .DEB_CYCLES(DEB), .STEP(STEP),
        .PMIN(PMIN), .PMAX(PMAX), .PRESET(PRESET)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (pif.slave)
    );

    int         tests = 0;
    int         fails = 0;
    int         step_q[$];
    int         move_q[$];
    int         model_pos;
    logic [1:0] cur_lvl;
    bit         exp_err;

    // Position of a level around the quadrature cycle 00,01,11,10.
    function automatic int gidx(input logic [1:0] l);
        return 2 * int'(l[1]) + int'(l[1] ^ l[0]);
    endfunction

    function automatic logic [1:0] glvl(input int i);
        logic [1:0] k;
        k = 2'(i);
        return {k[1], k[1] ^ k[0]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic move_to(input logic [1:0] lvl, input int hold);
        int d;
        @(posedge clk); #1;
        d = (gidx(lvl) - gidx(cur_lvl) + 4) % 4;
        if (d == 1) begin
            step_q.push_back(1);
            model_pos = (model_pos + STEP > PMAX) ? PMAX : model_pos + STEP;
        end else if (d == 3) begin
            step_q.push_back(-1);
            model_pos = (model_pos - STEP < PMIN) ? PMIN : model_pos - STEP;
        end else if (d == 2) begin
            exp_err = 1'b1;
        end
        cur_lvl = lvl;
        pif.a   = lvl[1];
        pif.b   = lvl[0];
        repeat (hold) @(posedge clk);
    endtask

    task automatic turn(input int dir, input int hold);
        move_to(glvl((gidx(cur_lvl) + dir + 4) % 4), hold);
    endtask

    task automatic glitch(input bit on_a);
        @(posedge clk); #1;
        if (on_a) pif.a = ~cur_lvl[1];
        else      pif.b = ~cur_lvl[0];
        repeat (2) @(posedge clk); #1;
        pif.a = cur_lvl[1];
        pif.b = cur_lvl[0];
        repeat (LAT + 2) @(posedge clk);
    endtask

    task automatic frame(input int expv);
        @(posedge clk); #1;
        pif.vsync = 1'b1;
        move_q.push_back(expv);
        repeat (2) @(posedge clk); #1;
        pif.vsync = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset(input logic [1:0] lvl, input int cycles);
        @(posedge clk); #1;
        rst_n     = 1'b0;
        pif.a     = lvl[1];
        pif.b     = lvl[0];
        pif.vsync = 1'b0;
        step_q.delete();
        move_q.delete();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check("rst_move", int'(pif.move), PRESET);
        check("rst_err", int'(pif.err), 0);
        check("rst_steps", int'(pif.step_up | pif.step_dn), 0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        model_pos = PRESET;
        cur_lvl   = lvl;
        exp_err   = 1'b0;
        repeat (DEB + 8) @(posedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT pulses a step or latches a frame.
    initial begin
        bit pend;
        bit vprev;
        int last_move;
        pend = 1'b0;
        vprev = 1'b0;
        last_move = PRESET;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
                vprev = 1'b0;
                last_move = int'(pif.move);
            end else begin
                if (pend) begin
                    if (move_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL move_latch: unexpected latch, got %0d, expected none", pif.move);
                    end else begin
                        check("move_latch", int'(pif.move), move_q.pop_front());
                    end
                    last_move = int'(pif.move);
                    pend = 1'b0;
                end else if (int'(pif.move) != last_move) begin
                    tests++; fails++;
                    $display("FAIL move_stable: got %0d, expected %0d", pif.move, last_move);
                    last_move = int'(pif.move);
                end
                if (pif.vsync && !vprev) pend = 1'b1;
                vprev = pif.vsync;
                if (pif.step_up || pif.step_dn) begin
                    if (step_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL step_unexpected: got up=%0b dn=%0b, expected no pulse", pif.step_up, pif.step_dn);
                    end else begin
                        check("step_dir", int'(pif.step_dn) - int'(pif.step_up), step_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        int r;
        pif.a = 1'b1; pif.b = 1'b1; pif.vsync = 1'b0;
        model_pos = PRESET; cur_lvl = 2'b11; exp_err = 1'b0;

        // Power-on level must not produce steps or err.
        do_reset(2'b11, 3);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("arm_err", int'(pif.err), 0);
        frame(PRESET);

        // One full forward cycle from 00.
        do_reset(2'b00, 3);
        repeat (4) turn(1, 10);
        frame(PRESET + 4 * STEP);

        // Short glitch is filtered; the next real edge decodes from the old level.
        glitch(1'b1);
        frame(model_pos);
        turn(1, LAT + 2);
        frame(model_pos);

        // Saturation at PMAX, then one step back.
        repeat (120) turn(1, DEB + 2);
        frame(PMAX);
        turn(-1, LAT + 2);
        frame(PMAX - STEP);

        // Illegal double change sets sticky err without moving.
        while (cur_lvl != 2'b00) turn(-1, LAT + 2);
        saved = model_pos;
        move_to(2'b11, LAT + 3);
        @(negedge clk);
        check("err_set", int'(pif.err), int'(exp_err));
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("err_sticky", int'(pif.err), 1);
        frame(saved);
        do_reset(2'b11, 2);

        // Step coinciding with the frame edge: old value now, new value next frame.
        saved = model_pos;
        turn(1, LAT - 2);
        frame(saved);
        frame(model_pos);
        saved = model_pos;
        turn(-1, LAT - 2);
        frame(saved);
        turn(1, 3);
        do_reset(cur_lvl, 2);

        // Randomised walk against the model.
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       turn(1, $urandom_range(LAT, LAT + 5));
            else if (r < 8)  turn(-1, $urandom_range(LAT, LAT + 5));
            else if (r == 8) glitch($urandom_range(0, 1) == 1);
            else             frame(model_pos);
        end
        frame(model_pos);
        @(negedge clk);
        check("rand_err", int'(pif.err), int'(exp_err));

        repeat (10) @(posedge clk);
        check("step_q_drained", step_q.size(), 0);
        check("move_q_drained", move_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
